// File: rtl/round_decrypt_pkg.sv
// Shared definitions for the SPECK single-round decryption engine:
// default word/rotate widths and the FSM state encoding.
package round_decrypt_pkg;

    localparam int DEFAULT_BLOCK_SIZE     = 32;
    localparam int DEFAULT_SHIFT_WIDTH_P0 = 8;
    localparam int DEFAULT_SHIFT_WIDTH_P1 = 3;

    // Codes 8..15 are unused; the FSM recovers from them to WAIT_FOR_START_DECRYPT.
    typedef enum logic [3:0] {
        WAIT_FOR_START_DECRYPT = 4'd0,
        ASSIGN_DECRYPT         = 4'd1,
        XOR_P0_P1_DECRYPT      = 4'd2,
        ROTATE_XOR_SUBKEY      = 4'd3,
        SUBTRACT_DECRYPT       = 4'd4,
        ROTATE_P0_DECRYPT      = 4'd5,
        RESULT_DECRYPT         = 4'd6,
        DONE_DECRYPT           = 4'd7
    } state_t;

    localparam logic [3:0] MAX_STATE_DECRYPT = 4'd7;

endpackage

// File: rtl/round_decrypt.sv
// Inverts one SPECK encryption round over several cycles:
// p1 = ROR(c1 ^ c0, beta); p0 = ROL((c0 ^ subkey) - p1, alpha).
module round_decrypt
    import round_decrypt_pkg::*;
#(
    parameter int BLOCK_SIZE     = DEFAULT_BLOCK_SIZE,
    parameter int SHIFT_WIDTH_P0 = DEFAULT_SHIFT_WIDTH_P0,
    parameter int SHIFT_WIDTH_P1 = DEFAULT_SHIFT_WIDTH_P1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BLOCK_SIZE-1:0]     subkey,
    input  logic [2*BLOCK_SIZE-1:0]   ciphertext,
    input  logic                      signal_start,
    output logic [2*BLOCK_SIZE-1:0]   plaintext,
    output logic                      finished,
    output logic [3:0]                state_response
);

    function automatic logic [BLOCK_SIZE-1:0] shift_left(input logic [BLOCK_SIZE-1:0] value,
                                                         input int unsigned amount);
        return (value << amount) | (value >> (BLOCK_SIZE - amount));
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] shift_right(input logic [BLOCK_SIZE-1:0] value,
                                                          input int unsigned amount);
        return (value >> amount) | (value << (BLOCK_SIZE - amount));
    endfunction

    state_t                    state, state_next;
    logic [BLOCK_SIZE-1:0]     p0, p0_next;
    logic [BLOCK_SIZE-1:0]     p1, p1_next;
    logic [BLOCK_SIZE-1:0]     subkey_r, subkey_r_next;
    logic [2*BLOCK_SIZE-1:0]   plaintext_next;
    logic                      finished_next;

    always_comb begin
        // NOTE: every output gets a hold-value default first, so no path leaves a latch.
        state_next     = state;
        p0_next        = p0;
        p1_next        = p1;
        subkey_r_next  = subkey_r;
        plaintext_next = plaintext;
        finished_next  = finished;

        case (state)
            WAIT_FOR_START_DECRYPT: begin
                finished_next = 1'b0;
                if (signal_start) state_next = ASSIGN_DECRYPT;
            end
            ASSIGN_DECRYPT: begin
                p0_next       = ciphertext[BLOCK_SIZE-1:0];
                p1_next       = ciphertext[2*BLOCK_SIZE-1:BLOCK_SIZE];
                subkey_r_next = subkey;
                state_next    = XOR_P0_P1_DECRYPT;
            end
            XOR_P0_P1_DECRYPT: begin
                p1_next    = p0 ^ p1;
                state_next = ROTATE_XOR_SUBKEY;
            end
            ROTATE_XOR_SUBKEY: begin
                p1_next    = shift_right(p1, SHIFT_WIDTH_P1);
                p0_next    = p0 ^ subkey_r;
                state_next = SUBTRACT_DECRYPT;
            end
            SUBTRACT_DECRYPT: begin
                p0_next    = p0 - p1;
                state_next = ROTATE_P0_DECRYPT;
            end
            ROTATE_P0_DECRYPT: begin
                p0_next    = shift_left(p0, SHIFT_WIDTH_P0);
                state_next = RESULT_DECRYPT;
            end
            RESULT_DECRYPT: begin
                plaintext_next = {p1, p0};
                finished_next  = 1'b1;
                state_next     = DONE_DECRYPT;
            end
            DONE_DECRYPT: begin
                // Holding start high keeps us here, so a held request runs only once.
                if (!signal_start) begin
                    finished_next = 1'b0;
                    state_next    = WAIT_FOR_START_DECRYPT;
                end
            end
            default: begin
                finished_next = 1'b0;
                state_next    = WAIT_FOR_START_DECRYPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= WAIT_FOR_START_DECRYPT;
            p0        <= '0;
            p1        <= '0;
            subkey_r  <= '0;
            plaintext <= '0;
            finished  <= 1'b0;
        end else begin
            state     <= state_next;
            p0        <= p0_next;
            p1        <= p1_next;
            subkey_r  <= subkey_r_next;
            plaintext <= plaintext_next;
            finished  <= finished_next;
        end
    end

    assign state_response = state;

endmodule

// File: tb/tb_round_decrypt.sv
// Self-checking bench for round_decrypt: directed handshake/reset cases plus
// random round trips through a behavioural SPECK round-encrypt model.
module tb_round_decrypt;

    localparam int BS    = 32;
    localparam int ALPHA = 8;
    localparam int BETA  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [BS-1:0]   subkey;
    logic [2*BS-1:0] ciphertext;
    logic            signal_start;
    logic [2*BS-1:0] plaintext;
    logic            finished;
    logic [3:0]      state_response;

    int test_count = 0;
    int fail_count = 0;

    round_decrypt #(
        .BLOCK_SIZE    (BS),
        .SHIFT_WIDTH_P0(ALPHA),
        .SHIFT_WIDTH_P1(BETA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .subkey        (subkey),
        .ciphertext    (ciphertext),
        .signal_start  (signal_start),
        .plaintext     (plaintext),
        .finished      (finished),
        .state_response(state_response)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference rotations as plain modular arithmetic on 32-bit words.
    function automatic logic [31:0] rot_left(input logic [31:0] x, input int n);
        logic [63:0] wide;
        wide = {x, x} << n;
        return wide[63:32];
    endfunction

    function automatic logic [31:0] rot_right(input logic [31:0] x, input int n);
        return rot_left(x, 32 - n);
    endfunction

    // Forward SPECK round: c0 = (ROR(p0,a) + p1) ^ k; c1 = ROL(p1,b) ^ c0.
    function automatic logic [63:0] encrypt_model(input logic [63:0] pt, input logic [31:0] k);
        logic [31:0] c0, c1;
        c0 = (rot_right(pt[31:0], ALPHA) + pt[63:32]) ^ k;
        c1 = rot_left(pt[63:32], BETA) ^ c0;
        return {c1, c0};
    endfunction

    function automatic logic [63:0] decrypt_model(input logic [63:0] ct, input logic [31:0] k);
        logic [31:0] q0, q1;
        q1 = rot_right(ct[63:32] ^ ct[31:0], BETA);
        q0 = rot_left((ct[31:0] ^ k) - q1, ALPHA);
        return {q1, q0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [63:0] c, input logic [31:0] k,
                          output logic [63:0] result);
        int lat;
        ciphertext   = c;
        subkey       = k;
        signal_start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!finished && lat < 30);
        check("latency", 64'(lat), 64'd7);
        result       = plaintext;
        signal_start = 1'b0;
        tick();
        check("finished_drop", {63'd0, finished}, 64'd0);
    endtask

    initial begin
        logic [63:0] res, pt, ct, held;
        logic [31:0] k;
        int rises, pulses, lat;
        logic prev_fin;

        rst = 1'b1;
        signal_start = 1'b0;
        subkey = '0;
        ciphertext = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", {60'd0, state_response}, 64'd0);
        check("reset_finished", {63'd0, finished}, 64'd0);
        check("reset_plaintext", plaintext, 64'd0);

        run_op(64'h0, 32'h0000_0001, res);
        check("subkey_only", res, 64'h0000_0000_0000_0100);

        run_op(64'h0000_0008_0000_0000, 32'h0, res);
        check("borrow_wrap", res, 64'h0000_0001_FFFF_FFFF);
        held = res;

        // Start held high for 20 cycles: one operation, state climbs 1..7 then sits in 7.
        ciphertext = {$urandom, $urandom};
        subkey = $urandom;
        ct = ciphertext;
        k = subkey;
        check("hs_idle_state", {60'd0, state_response}, 64'd0);
        signal_start = 1'b1;
        rises = 0;
        prev_fin = finished;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("hs_state_%0d", i), {60'd0, state_response}, 64'((i < 7) ? i : 7));
            if (finished && !prev_fin) rises++;
            prev_fin = finished;
        end
        check("hs_one_rise", 64'(rises), 64'd1);
        check("hs_result", plaintext, decrypt_model(ct, k));
        signal_start = 1'b0;
        tick();
        check("hs_fall", {63'd0, finished}, 64'd0);
        check("hs_back_to_wait", {60'd0, state_response}, 64'd0);

        // Reset while in SUBTRACT aborts the operation and clears the previous result.
        ciphertext = {$urandom, $urandom};
        subkey = $urandom;
        signal_start = 1'b1;
        repeat (4) tick();
        check("midop_state", {60'd0, state_response}, 64'd4);
        rst = 1'b1;
        signal_start = 1'b0;
        tick();
        tick();
        check("midop_reset_state", {60'd0, state_response}, 64'd0);
        check("midop_reset_finished", {63'd0, finished}, 64'd0);
        check("midop_reset_plaintext", plaintext, 64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (finished) pulses++;
        end
        check("midop_no_pulse", 64'(pulses), 64'd0);
        check("midop_plaintext_held", plaintext, 64'd0);

        // Inputs scrambled every cycle after ASSIGN, start dropped early: result uses sampled values.
        ct = {$urandom, $urandom};
        k = $urandom;
        ciphertext = ct;
        subkey = k;
        signal_start = 1'b1;
        tick();
        tick();
        signal_start = 1'b0;
        lat = 2;
        while (!finished && lat < 30) begin
            ciphertext = {$urandom, $urandom};
            subkey = $urandom;
            tick();
            lat++;
        end
        check("indep_latency", 64'(lat), 64'd7);
        check("indep_result", plaintext, decrypt_model(ct, k));
        tick();
        check("indep_finished_drop", {63'd0, finished}, 64'd0);

        // Round trips, with all-zero and all-one words first.
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0:       begin pt = 64'h0;                    k = 32'h0;         end
                1:       begin pt = '1;                       k = 32'hFFFF_FFFF; end
                2:       begin pt = 64'hFFFF_FFFF_0000_0000;  k = 32'h0;         end
                3:       begin pt = 64'h0000_0000_FFFF_FFFF;  k = 32'hFFFF_FFFF; end
                default: begin pt = {$urandom, $urandom};     k = $urandom;      end
            endcase
            run_op(encrypt_model(pt, k), k, res);
            check($sformatf("round_trip_%0d", i), res, pt);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/round_decrypt.md
# round_decrypt

Single SPECK round decryption engine: inverts one encryption round, recovering the round-input block from a round-output block and that round's subkey. Multi-cycle state machine with a start/finished handshake. A key-schedule/round controller instantiates it and feeds subkeys in reverse round order to decrypt a full ciphertext.

## Interface
Parameters:
- BLOCK_SIZE, 32, word width; the data block is 2*BLOCK_SIZE.
- SHIFT_WIDTH_P0, 8, alpha; left-rotate amount applied to p0 in decryption.
- SHIFT_WIDTH_P1, 3, beta; right-rotate amount applied to p1 in decryption.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- subkey  in  BLOCK_SIZE  round subkey; sampled in ASSIGN.
- ciphertext  in  2*BLOCK_SIZE  round output; [BLOCK_SIZE-1:0]=c0, upper word=c1; sampled in ASSIGN.
- signal_start  in  1  start request level.
- plaintext  out  2*BLOCK_SIZE  round input; [BLOCK_SIZE-1:0]=p0, upper word=p1; registered.
- finished  out  1  result valid; registered.
- state_response  out  4  current state code, debug only.

## Operation
- Function: p1 = ROR(c1 ^ c0, beta); p0 = ROL((c0 ^ subkey) - p1, alpha). All rotations are circular. Subtraction is modulo 2^BLOCK_SIZE; the borrow is discarded.
- Internal registers: p0, p1 (BLOCK_SIZE each), subkey_r (BLOCK_SIZE), state (4 bits).
- States and transitions:
  - 0 WAIT: finished<=0. If signal_start=1, go to ASSIGN.
  - 1 ASSIGN: p0<=c0, p1<=c1, subkey_r<=subkey. Go to 2.
  - 2 XOR_P0_P1: p1<=p0^p1. Go to 3.
  - 3 ROTATE_XOR_SUBKEY: p1<=ROR(p1,beta); p0<=p0^subkey_r. Both updates happen in the same cycle. Go to 4.
  - 4 SUBTRACT: p0<=p0-p1. Go to 5.
  - 5 ROTATE_P0: p0<=ROL(p0,alpha). Go to 6.
  - 6 RESULT: plaintext<={p1,p0}; finished<=1. Go to 7.
  - 7 DONE: hold plaintext and finished. If signal_start=0, go to WAIT and clear finished on that edge.
- Codes 8–15 are unreachable. If ever entered, go to WAIT with finished<=0.
- ciphertext and subkey are ignored outside ASSIGN, so inputs may change freely after that cycle.
- plaintext changes only in RESULT or on reset. Outside those, it holds the last result.

## Timing
- Reset values: state=WAIT, finished=0, plaintext=0, p0=p1=subkey_r=0, state_response=0.
- Reset has priority over every state. A reset mid-operation aborts the operation: no finished pulse and no plaintext update.
- Latency: signal_start is sampled high at edge E. finished=1 and plaintext are valid after edge E+6.
- finished stays high for as long as signal_start stays high; minimum 1 cycle.
- Handshake: the requester holds signal_start high until it sees finished, then drops it. finished falls on the first edge at which signal_start=0 is sampled in DONE.
- signal_start held high permanently yields exactly one operation. A new operation requires signal_start to go low, then high again.
- Back-to-back operations: minimum period is 8 cycles (WAIT→…→DONE→WAIT).
- signal_start low during states 1–6 has no effect; the operation completes.

## Structure
- State codes (WAIT_FOR_START_DECRYPT … DONE_DECRYPT) and MAX_STATE_DECRYPT belong in round_function_defines.vh, alongside the encrypt codes.
- BLOCK_SIZE and shift defaults belong in cipher_settings.vh.
- Circular rotate helpers (shift_left, shift_right) come from general_functions.v, shared with the encryptor.
- No sub-module: the datapath is two registers and four operators. The rotates are functions, not instances.

## Test plan
- Reset: assert rst for 2 cycles mid-operation (state 4) -> state_response=0, finished=0, plaintext=0. No finished pulse follows.
- Subkey only: c0=0, c1=0, subkey=0x00000001, start -> after 7 cycles plaintext={p1=0x00000000, p0=0x00000100}, finished=1.
- Borrow wrap: c0=0, c1=0x00000008, subkey=0 -> p1=0x00000001, p0=0xFFFFFFFF.
- Handshake: hold signal_start high 20 cycles -> exactly one finished rise. finished falls one edge after signal_start drops. state_response sequence is 0,1,2,3,4,5,6,7,…,7,0.
- Input independence: change ciphertext/subkey every cycle after ASSIGN -> result equals the values sampled in ASSIGN.
- Round trip: 1000 random (pt, subkey) pairs through round_encrypt, then round_decrypt with the same subkey -> plaintext equals the original pt. Include all-ones and all-zeros words.
